mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Memory-stage execution unit of the 5-stage MIPS pipeline: consumes the M-stage register outputs (control, ALU result, store data, destination, PC), performs the data-memory access against an internal word RAM with a configurable access latency, and produces the registered W-stage inputs. It drives `stall` back to the hazard logic to freeze F/D/E/M while a multi-cycle load or store is in flight. Non-memory instructions pass through in one cycle.

## Interface
- `ADDR_WIDTH`, 10: word-address bits; RAM depth 2^ADDR_WIDTH words.
- `LATENCY`, 2: cycles per memory access, legal range 1..8.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `RegWrite_in`  in  1  instruction writes the GPR.
- `MemWrite_in`  in  1  store.
- `MemToReg_in`  in  1  load; W selects memory data.
- `ALUOut_in`  in  32  byte address for loads and stores, otherwise the ALU result.
- `WriteData_in`  in  32  store data.
- `RegAddr_in`  in  5  destination GPR.
- `pc_in`  in  32  instruction PC.
- `stall`  out  1  combinational; high while an access is incomplete.
- `RegWrite_out`, `MemToReg_out`  out  1 each  registered W-stage controls.
- `ALUOut_out`, `ReadData_out`, `pc_out`  out  32 each  registered W-stage data.
- `RegAddr_out`  out  5  registered W-stage destination.
- `mem_wr_valid`  out  1  one-cycle pulse after a store commits.
- `mem_wr_addr`, `mem_wr_data`, `mem_wr_pc`  out  32 each  byte address, data and PC of the committed store.

## Operation
- Memory op: `MemWrite_in | MemToReg_in`. Both high is illegal; the op is treated as a store.
- Word index: `ALUOut_in[ADDR_WIDTH+1:2]`. Bits [1:0] and the bits above the index are ignored, so addresses wrap modulo the RAM size.
- FSM states: IDLE and BUSY. The counter is 3 bits wide.
  - IDLE, no memory op: W registers load the inputs on the next edge. `ReadData_out` is 0.
  - IDLE, memory op, `LATENCY==1`: the access completes on this edge (see completion).
  - IDLE, memory op, `LATENCY>1`: capture all inputs into holding registers, set cnt = LATENCY-2, go to BUSY. W registers load a bubble (all zeros).
  - BUSY, cnt != 0: decrement cnt. W registers load a bubble. Input changes are ignored.
  - BUSY, cnt == 0: the access completes on this edge, then the FSM returns to IDLE.
- Completion edge:
  - Store: RAM[index] <= data.
  - Load: `ReadData_out` <= RAM[index], the value before any write on the same edge.
  - W registers load the held or current controls, address and PC.
  - For a store, the trace outputs load the address, data and PC, and `mem_wr_valid` goes to 1 for one cycle.
- `stall` = (IDLE & memop & LATENCY>1) | (BUSY & cnt != 0). `stall` is low in the completion cycle, so upstream advances on that edge.
- Upstream holds its inputs stable while `stall` is high. The block does not depend on this because the inputs are captured.

## Timing
- Reset:
  - All outputs are 0. The FSM goes to IDLE and cnt to 0.
  - Every RAM word is cleared to 0.
  - `stall` reads 0 from the cycle after reset.
- Reset during BUSY: the access is aborted, no RAM write happens and no `mem_wr_valid` pulse is issued.
- Latency:
  - A non-memory op presented in cycle t appears on the W outputs in cycle t+1.
  - A memory op presented in cycle t keeps `stall` high for cycles t..t+LATENCY-2.
  - Its W outputs and `mem_wr_valid` appear in cycle t+LATENCY.
  - Bubbles appear on W in cycles t+1..t+LATENCY-1.
- Back-to-back memory ops: the next op is accepted in the cycle immediately after completion. There are no extra idle cycles, so throughput is one op per LATENCY cycles.
- Load after store to the same word, in the next op: the load returns the stored value.
- A bubble op (all inputs zero) passes through as zeros and never writes memory.

## Test plan
- Reset, then an ALU op: LATENCY=2; reset for 2 cycles and check all outputs are 0. Present RegWrite=1, ALUOut=0x1234, RegAddr=5, pc=0x3000 -> next cycle W shows the same values, `ReadData_out`=0, `stall` never rises.
- Store: LATENCY=3; present sw with addr 0x10, data 0xDEADBEEF -> `stall` high for 2 cycles, W bubbles for 2 cycles. In cycle t+3, `mem_wr_valid`=1, `mem_wr_addr`=0x10, `mem_wr_data`=0xDEADBEEF.
- Store then load: store 0xCAFEF00D at 0x20, then load from 0x23 with RegAddr=8 -> `ReadData_out`=0xCAFEF00D, `MemToReg_out`=1, `RegAddr_out`=8. Also check that 0x20 + 4·2^ADDR_WIDTH aliases to the same word.
- Input glitch during stall: change `WriteData_in` to 0x1 mid-BUSY -> 0xDEADBEEF is still the value committed.
- Reset mid-access: assert reset in BUSY of a store to 0x40 -> no `mem_wr_valid`, and a later load from 0x40 returns 0.
- LATENCY=1 sweep: alternate loads and stores every cycle -> `stall` stays 0 throughout, every W result lands one cycle later.

Source files
------------

// File: rtl/mem_access_unit.sv
// Memory stage of the 5-stage MIPS pipeline: word RAM with configurable access latency,
// stalls upstream during multi-cycle accesses and registers the W-stage inputs.
module mem_access_unit #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWrite_in,
    input  logic        MemWrite_in,
    input  logic        MemToReg_in,
    input  logic [31:0] ALUOut_in,
    input  logic [31:0] WriteData_in,
    input  logic [4:0]  RegAddr_in,
    input  logic [31:0] pc_in,
    output logic        stall,
    output logic        RegWrite_out,
    output logic        MemToReg_out,
    output logic [31:0] ALUOut_out,
    output logic [31:0] ReadData_out,
    output logic [31:0] pc_out,
    output logic [4:0]  RegAddr_out,
    output logic        mem_wr_valid,
    output logic [31:0] mem_wr_addr,
    output logic [31:0] mem_wr_data,
    output logic [31:0] mem_wr_pc
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam bit       MULTI    = (LATENCY > 1);
    localparam logic [2:0] CNT_INIT = (LATENCY > 1) ? 3'(LATENCY - 2) : 3'd0;

    state_t      state_q;
    logic [2:0]  cnt_q;
    logic        hRegWrite_q, hMemWrite_q, hMemToReg_q;
    logic [31:0] hAddr_q, hData_q, hPc_q;
    logic [4:0]  hRegAddr_q;
    logic [31:0] mem_q [2**ADDR_WIDTH];

    logic        memOp, useHeld, complete, passThru, isStore, isLoad;
    logic        opRegWrite, opMemWrite, opMemToReg;
    logic [31:0] opAddr, opData, opPc;
    logic [4:0]  opRegAddr;
    logic [ADDR_WIDTH-1:0] index;

    // While BUSY the captured instruction is authoritative; live inputs are ignored.
    always_comb begin
        memOp      = MemWrite_in | MemToReg_in;
        useHeld    = (state_q == BUSY);
        opRegWrite = useHeld ? hRegWrite_q : RegWrite_in;
        opMemWrite = useHeld ? hMemWrite_q : MemWrite_in;
        opMemToReg = useHeld ? hMemToReg_q : MemToReg_in;
        opAddr     = useHeld ? hAddr_q     : ALUOut_in;
        opData     = useHeld ? hData_q     : WriteData_in;
        opRegAddr  = useHeld ? hRegAddr_q  : RegAddr_in;
        opPc       = useHeld ? hPc_q       : pc_in;
        isStore    = opMemWrite;
        isLoad     = opMemToReg & ~opMemWrite;
        index      = opAddr[ADDR_WIDTH+1:2];
        complete   = ((state_q == IDLE) && memOp && !MULTI) ||
                     ((state_q == BUSY) && (cnt_q == 3'd0));
        passThru   = complete || ((state_q == IDLE) && !memOp);
        stall      = ((state_q == IDLE) && memOp && MULTI) ||
                     ((state_q == BUSY) && (cnt_q != 3'd0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            hRegWrite_q  <= 1'b0;
            hMemWrite_q  <= 1'b0;
            hMemToReg_q  <= 1'b0;
            hAddr_q      <= '0;
            hData_q      <= '0;
            hRegAddr_q   <= '0;
            hPc_q        <= '0;
            RegWrite_out <= 1'b0;
            MemToReg_out <= 1'b0;
            ALUOut_out   <= '0;
            ReadData_out <= '0;
            pc_out       <= '0;
            RegAddr_out  <= '0;
            mem_wr_valid <= 1'b0;
            mem_wr_addr  <= '0;
            mem_wr_data  <= '0;
            mem_wr_pc    <= '0;
            for (int i = 0; i < 2**ADDR_WIDTH; i++) mem_q[i] <= '0;
        end else begin
            mem_wr_valid <= 1'b0;

            // Non-passing cycles put a bubble on W.
            RegWrite_out <= passThru ? opRegWrite : 1'b0;
            MemToReg_out <= passThru ? opMemToReg : 1'b0;
            ALUOut_out   <= passThru ? opAddr     : '0;
            RegAddr_out  <= passThru ? opRegAddr  : '0;
            pc_out       <= passThru ? opPc       : '0;
            ReadData_out <= (complete && isLoad) ? mem_q[index] : '0;

            if (complete && isStore) begin
                mem_q[index] <= opData;
                mem_wr_valid <= 1'b1;
                mem_wr_addr  <= opAddr;
                mem_wr_data  <= opData;
                mem_wr_pc    <= opPc;
            end

            case (state_q)
                IDLE: begin
                    if (memOp && MULTI) begin
                        hRegWrite_q <= RegWrite_in;
                        hMemWrite_q <= MemWrite_in;
                        hMemToReg_q <= MemToReg_in;
                        hAddr_q     <= ALUOut_in;
                        hData_q     <= WriteData_in;
                        hRegAddr_q  <= RegAddr_in;
                        hPc_q       <= pc_in;
                        cnt_q       <= CNT_INIT;
                        state_q     <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_q != 3'd0) cnt_q <= cnt_q - 3'd1;
                    else state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: three instances with LATENCY 2, 3 and 1
// sharing clock and reset, each driven from its own input set.
module tb_mem_access_unit;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        rwI [3], mwI [3], mtrI [3];
    logic [31:0] aluI [3], wdI [3], pcI [3];
    logic [4:0]  raI [3];
    logic        stallO [3], rwO [3], mtrO [3], wvO [3];
    logic [31:0] aluO [3], rdO [3], pcO [3], waO [3], wdO [3], wpO [3];
    logic [4:0]  raO [3];

    int errors = 0;
    int checks = 0;

    for (genvar g = 0; g < 3; g++) begin : gDut
        mem_access_unit #(
            .ADDR_WIDTH(10),
            .LATENCY   ((g == 0) ? 2 : ((g == 1) ? 3 : 1))
        ) u (
            .clk         (clk),
            .rst         (rst),
            .RegWrite_in (rwI[g]),
            .MemWrite_in (mwI[g]),
            .MemToReg_in (mtrI[g]),
            .ALUOut_in   (aluI[g]),
            .WriteData_in(wdI[g]),
            .RegAddr_in  (raI[g]),
            .pc_in       (pcI[g]),
            .stall       (stallO[g]),
            .RegWrite_out(rwO[g]),
            .MemToReg_out(mtrO[g]),
            .ALUOut_out  (aluO[g]),
            .ReadData_out(rdO[g]),
            .pc_out      (pcO[g]),
            .RegAddr_out (raO[g]),
            .mem_wr_valid(wvO[g]),
            .mem_wr_addr (waO[g]),
            .mem_wr_data (wdO[g]),
            .mem_wr_pc   (wpO[g])
        );
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int k, input logic rw, input logic mw, input logic mtr,
                                 input logic [31:0] alu, input logic [31:0] wd,
                                 input logic [4:0] ra, input logic [31:0] pc);
        rwI[k]  = rw;
        mwI[k]  = mw;
        mtrI[k] = mtr;
        aluI[k] = alu;
        wdI[k]  = wd;
        raI[k]  = ra;
        pcI[k]  = pc;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One LATENCY=1 op per cycle: {MemWrite, MemToReg, RegWrite, addr, data, regaddr, pc, expected read}
    typedef struct {
        logic        mw, mtr, rw;
        logic [31:0] alu, wd;
        logic [4:0]  ra;
        logic [31:0] pc, expRd;
    } vec_t;
    vec_t sweep [6];

    initial begin
        sweep[0] = '{1'b1, 1'b0, 1'b0, 32'h0,  32'h11111111, 5'd0, 32'h400, 32'h0};
        sweep[1] = '{1'b0, 1'b1, 1'b1, 32'h0,  32'h0,        5'd3, 32'h404, 32'h11111111};
        sweep[2] = '{1'b1, 1'b0, 1'b0, 32'h8,  32'h22222222, 5'd0, 32'h408, 32'h0};
        sweep[3] = '{1'b0, 1'b1, 1'b1, 32'h8,  32'h0,        5'd4, 32'h40C, 32'h22222222};
        sweep[4] = '{1'b0, 1'b1, 1'b1, 32'h3,  32'h0,        5'd5, 32'h410, 32'h11111111};
        sweep[5] = '{1'b0, 1'b0, 1'b1, 32'h77, 32'h0,        5'd6, 32'h414, 32'h0};

        rst = 1'b1;
        for (int k = 0; k < 3; k++) applyStimulus(k, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        checkOutput("rst_regwrite", 32'(rwO[0]), 0);
        checkOutput("rst_aluout", aluO[0], 0);
        checkOutput("rst_pc", pcO[0], 0);
        checkOutput("rst_wrvalid", 32'(wvO[1]), 0);
        checkOutput("rst_stall", 32'(stallO[0]), 0);
        rst = 1'b0;

        // ALU op through LATENCY=2 instance
        applyStimulus(0, 1, 0, 0, 32'h1234, 0, 5'd5, 32'h3000);
        checkOutput("alu_stall", 32'(stallO[0]), 0);
        tick();
        checkOutput("alu_regwrite", 32'(rwO[0]), 1);
        checkOutput("alu_aluout", aluO[0], 32'h1234);
        checkOutput("alu_regaddr", 32'(raO[0]), 5);
        checkOutput("alu_pc", pcO[0], 32'h3000);
        checkOutput("alu_readdata", rdO[0], 0);
        applyStimulus(0, 1, 0, 1, 32'h0, 0, 5'd2, 32'h500);
        checkOutput("l2_ld_stall_t", 32'(stallO[0]), 1);
        tick();
        checkOutput("l2_ld_stall_t1", 32'(stallO[0]), 0);
        checkOutput("l2_ld_bubble_pc", pcO[0], 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("l2_ld_pc", pcO[0], 32'h500);
        checkOutput("l2_ld_memtoreg", 32'(mtrO[0]), 1);
        checkOutput("l2_ld_data", rdO[0], 0);

        // LATENCY=3 store with a data glitch mid-BUSY
        applyStimulus(1, 0, 1, 0, 32'h10, 32'hDEADBEEF, 0, 32'h100);
        checkOutput("st_stall_t", 32'(stallO[1]), 1);
        tick();
        checkOutput("st_stall_t1", 32'(stallO[1]), 1);
        checkOutput("st_bubble_alu", aluO[1], 0);
        applyStimulus(1, 0, 1, 0, 32'h10, 32'h1, 0, 32'h100);
        tick();
        checkOutput("st_stall_t2", 32'(stallO[1]), 0);
        checkOutput("st_bubble_pc", pcO[1], 0);
        tick();
        checkOutput("st_wrvalid", 32'(wvO[1]), 1);
        checkOutput("st_wraddr", waO[1], 32'h10);
        checkOutput("st_wrdata", wdO[1], 32'hDEADBEEF);
        checkOutput("st_wrpc", wpO[1], 32'h100);
        checkOutput("st_w_pc", pcO[1], 32'h100);

        // Back-to-back store accepted immediately, then load and aliased load
        applyStimulus(1, 0, 1, 0, 32'h20, 32'hCAFEF00D, 0, 32'h104);
        checkOutput("st2_stall", 32'(stallO[1]), 1);
        tick();
        checkOutput("st_pulse_end", 32'(wvO[1]), 0);
        tick();
        tick();
        checkOutput("st2_wrvalid", 32'(wvO[1]), 1);
        checkOutput("st2_wrdata", wdO[1], 32'hCAFEF00D);
        applyStimulus(1, 1, 0, 1, 32'h23, 0, 5'd8, 32'h108);
        tick();
        tick();
        tick();
        checkOutput("ld_data", rdO[1], 32'hCAFEF00D);
        checkOutput("ld_memtoreg", 32'(mtrO[1]), 1);
        checkOutput("ld_regaddr", 32'(raO[1]), 8);
        checkOutput("ld_wrvalid", 32'(wvO[1]), 0);
        applyStimulus(1, 1, 0, 1, 32'h1020, 0, 5'd9, 32'h10C);
        tick();
        tick();
        tick();
        checkOutput("alias_data", rdO[1], 32'hCAFEF00D);
        checkOutput("alias_regaddr", 32'(raO[1]), 9);
        applyStimulus(1, 1, 0, 1, 32'h10, 0, 5'd10, 32'h110);
        tick();
        tick();
        tick();
        checkOutput("glitch_data", rdO[1], 32'hDEADBEEF);

        // Reset while a store is in flight
        applyStimulus(1, 0, 1, 0, 32'h40, 32'h55, 0, 32'h200);
        tick();
        rst = 1'b1;
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        checkOutput("abort_wrvalid0", 32'(wvO[1]), 0);
        checkOutput("abort_stall", 32'(stallO[1]), 0);
        tick();
        tick();
        checkOutput("abort_wrvalid1", 32'(wvO[1]), 0);
        applyStimulus(1, 1, 0, 1, 32'h40, 0, 5'd11, 32'h204);
        tick();
        tick();
        tick();
        checkOutput("abort_ld_data", rdO[1], 0);
        checkOutput("abort_ld_pc", pcO[1], 32'h204);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);

        // LATENCY=1: one op per cycle, results one cycle later, no stall
        for (int i = 0; i < 6; i++) begin
            applyStimulus(2, sweep[i].rw, sweep[i].mw, sweep[i].mtr, sweep[i].alu,
                          sweep[i].wd, sweep[i].ra, sweep[i].pc);
            checkOutput($sformatf("l1_stall_%0d", i), 32'(stallO[2]), 0);
            tick();
            checkOutput($sformatf("l1_pc_%0d", i), pcO[2], sweep[i].pc);
            checkOutput($sformatf("l1_rd_%0d", i), rdO[2], sweep[i].expRd);
            checkOutput($sformatf("l1_wv_%0d", i), 32'(wvO[2]), 32'(sweep[i].mw));
            checkOutput($sformatf("l1_ra_%0d", i), 32'(raO[2]), 32'(sweep[i].ra));
        end
        applyStimulus(2, 0, 0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("l1_bubble_wv", 32'(wvO[2]), 0);
        checkOutput("l1_bubble_pc", pcO[2], 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
